// File: rtl/f_unpack_pkg.sv
// f_unpack_pkg
// Shared constants and types for the FPU operand unpacker and its neighbours.
// The quiet-NaN defaults are the MIPS legacy encodings also used by f_round.
package f_unpack_pkg;

    localparam int EXP_W           = 13;
    localparam int FRAC_W          = 108;
    localparam int FRAC_HIDDEN_BIT = 104;

    localparam logic [EXP_W-1:0] SINGLE_EXP_OFFSET = 13'd896;
    localparam logic [EXP_W-1:0] DOUBLE_EXP_MAX    = 13'd2047;

    localparam logic [31:0] QNAN_SINGLE = 32'h7FBF_FFFF;
    localparam logic [63:0] QNAN_DOUBLE = 64'h7FF7_FFFF_FFFF_FFFF;

    typedef enum logic {
        FMT_SINGLE = 1'b0,
        FMT_DOUBLE = 1'b1
    } fmt_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic denorm;
    } fclass_t;

endpackage

// File: rtl/f_unpack_if.sv
// f_unpack_if
// Bundles the unpacker's pipeline sideband, operand inputs and unpacked
// outputs.
//   master : drives a_wait, flush, info_in, operand, is_double, fs;
//            receives busy, info_out, sign, exp, frac and the class flags
//   slave  : the unpacker itself (opposite directions)
interface f_unpack_if
    import f_unpack_pkg::*;
#(
    parameter int info_width = 1
) ();

    logic                  a_wait;
    logic                  flush;
    logic                  busy;
    logic [info_width-1:0] info_in;
    logic [63:0]           operand;
    logic                  is_double;
    logic                  fs;
    logic [info_width-1:0] info_out;
    logic                  sign;
    logic [EXP_W-1:0]      exp;
    logic [FRAC_W-1:0]     frac;
    logic                  is_zero;
    logic                  is_inf;
    logic                  is_nan;
    logic                  is_snan;
    logic                  is_denorm;

    modport master (
        output a_wait, flush, info_in, operand, is_double, fs,
        input  busy, info_out, sign, exp, frac,
               is_zero, is_inf, is_nan, is_snan, is_denorm
    );

    modport slave (
        input  a_wait, flush, info_in, operand, is_double, fs,
        output busy, info_out, sign, exp, frac,
               is_zero, is_inf, is_nan, is_snan, is_denorm
    );

endinterface

// File: rtl/f_lzc53.sv
// f_lzc53
// Combinational 53-bit leading-zero counter.
//   i_data  : value to scan, MSB first
//   o_count : number of leading zeros, 53 when i_data is all zero
module f_lzc53 (
    input  logic [52:0] i_data,
    output logic [5:0]  o_count
);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        o_count = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (i_data[i]) begin
                o_count = 6'(52 - i);
            end
        end
    end

endmodule

// File: rtl/f_unpack.sv
// f_unpack
// Converts a packed IEEE-754 single/double operand into the FPU's internal
// unrounded form: sign, 13-bit two's-complement exponent (bias 1023) and a
// 108-bit significand with the leading 1 at bit 104. Denormals are
// normalised (or flushed to zero when fs is set) and class flags produced.
// Two-stage pipeline, frozen by a_wait; flush clears info bit 0 everywhere.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : f_unpack_if slave (operand in, unpacked result out)
module f_unpack
    import f_unpack_pkg::*;
#(
    parameter int info_width = 1
) (
    input  logic     clk,
    input  logic     resetn,
    f_unpack_if.slave bus
);

    fmt_e                  w_fmt;
    logic                  w_dbl;
    logic [10:0]           w_e;
    logic                  w_e_zero;
    logic                  w_e_max;
    logic [51:0]           w_f;
    logic                  w_f_nz;
    logic [52:0]           w_lzc_in;
    logic [5:0]            w_lz;
    fclass_t               w_class;
    logic [EXP_W-1:0]      w_pre_exp;
    logic                  w_shift;
    logic                  w_sign;
    logic [info_width-1:0] w_s0_info;
    logic [info_width-1:0] w_s1_info;
    logic [FRAC_W-1:0]     w_frac_base;
    logic [FRAC_W-1:0]     w_frac_n;
    logic [EXP_W-1:0]      w_exp_n;

    logic [info_width-1:0] r0_info;
    logic                  r0_sign;
    fclass_t               r0_class;
    logic [5:0]            r0_lz;
    logic [51:0]           r0_f;
    logic [EXP_W-1:0]      r0_pre_exp;
    logic                  r0_shift;

    logic [info_width-1:0] r1_info;
    logic                  r1_sign;
    fclass_t               r1_class;
    logic [EXP_W-1:0]      r1_exp;
    logic [FRAC_W-1:0]     r1_frac;

    // ---------------- stage 0: field extraction and classification
    assign w_fmt = fmt_e'(bus.is_double);
    assign w_dbl = (w_fmt == FMT_DOUBLE);

    assign w_e      = w_dbl ? bus.operand[62:52] : {3'b000, bus.operand[30:23]};
    assign w_e_max  = w_dbl ? (&bus.operand[62:52]) : (&bus.operand[30:23]);
    assign w_e_zero = ~|w_e;
    // Single fraction is left-justified so both formats share one datapath.
    assign w_f      = w_dbl ? bus.operand[51:0] : {bus.operand[22:0], 29'd0};
    assign w_f_nz   = |w_f;
    assign w_sign   = w_dbl ? bus.operand[63] : bus.operand[31];

    // Trailing 1s cap the count at the real fraction width.
    assign w_lzc_in = w_dbl ? {bus.operand[51:0], 1'b1}
                            : {bus.operand[22:0], {30{1'b1}}};

    f_lzc53 u_lzc (
        .i_data  (w_lzc_in),
        .o_count (w_lz)
    );

    assign w_shift = w_e_zero & w_f_nz & ~bus.fs;

    always_comb begin
        w_class.zero   = w_e_zero & (~w_f_nz | bus.fs);
        w_class.inf    = w_e_max & ~w_f_nz;
        w_class.nan    = w_e_max & w_f_nz;
        w_class.snan   = w_e_max & w_f_nz & w_f[51];
        w_class.denorm = w_e_zero & w_f_nz;
    end

    // Denormal exponents start at the format's minimum-biased value; the
    // leading-zero count is subtracted in stage 1.
    always_comb begin
        if (w_e_max) begin
            w_pre_exp = DOUBLE_EXP_MAX;
        end else if (w_e_zero) begin
            w_pre_exp = (w_shift && !w_dbl) ? SINGLE_EXP_OFFSET : '0;
        end else if (w_dbl) begin
            w_pre_exp = {2'b00, w_e};
        end else begin
            w_pre_exp = {5'd0, w_e[7:0]} + SINGLE_EXP_OFFSET;
        end
    end

    // Flush clears the valid bit even while stalled; other bits obey a_wait.
    always_comb begin
        w_s0_info = bus.a_wait ? r0_info : bus.info_in;
        w_s1_info = bus.a_wait ? r1_info : r0_info;
        if (bus.flush) begin
            w_s0_info[0] = 1'b0;
            w_s1_info[0] = 1'b0;
        end
    end

    // ---------------- stage 1: normalisation and final exponent
    assign w_frac_base = {4'd0, r0_f, 52'd0};

    always_comb begin
        if (r0_class.zero) begin
            w_frac_n = '0;
        end else if (r0_shift) begin
            w_frac_n = w_frac_base << (7'(r0_lz) + 7'd1);
        end else begin
            w_frac_n = w_frac_base | (108'd1 << FRAC_HIDDEN_BIT);
        end
    end

    assign w_exp_n = r0_shift ? (r0_pre_exp - {7'd0, r0_lz}) : r0_pre_exp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r0_info    <= '0;
            r0_sign    <= 1'b0;
            r0_class   <= '0;
            r0_lz      <= '0;
            r0_f       <= '0;
            r0_pre_exp <= '0;
            r0_shift   <= 1'b0;
            r1_info    <= '0;
            r1_sign    <= 1'b0;
            r1_class   <= '0;
            r1_exp     <= '0;
            r1_frac    <= '0;
        end else begin
            r0_info <= w_s0_info;
            r1_info <= w_s1_info;
            if (!bus.a_wait) begin
                r0_sign    <= w_sign;
                r0_class   <= w_class;
                r0_lz      <= w_lz;
                r0_f       <= w_f;
                r0_pre_exp <= w_pre_exp;
                r0_shift   <= w_shift;
                r1_sign    <= r0_sign;
                r1_class   <= r0_class;
                r1_exp     <= w_exp_n;
                r1_frac    <= w_frac_n;
            end
        end
    end

    assign bus.busy      = bus.a_wait;
    assign bus.info_out  = r1_info;
    assign bus.sign      = r1_sign;
    assign bus.exp       = r1_exp;
    assign bus.frac      = r1_frac;
    assign bus.is_zero   = r1_class.zero;
    assign bus.is_inf    = r1_class.inf;
    assign bus.is_nan    = r1_class.nan;
    assign bus.is_snan   = r1_class.snan;
    assign bus.is_denorm = r1_class.denorm;

endmodule

// File: doc/f_unpack.md
# f_unpack

Operand unpacker for the FPU datapath. It converts a packed IEEE‑754 single or double operand into the internal unrounded format consumed by the arithmetic units and by f_round: sign, 13‑bit signed exponent biased by 1023, and a 108‑bit significand with the leading 1 at bit 104. Denormal inputs are normalised, and operand class flags are produced. It is a 2‑stage pipeline with the same a_wait/flush/info sideband discipline as the rest of the FPU.

## Interface
Parameters:
- info_width, default 1: sideband width. Bit 0 is the valid bit, cleared by flush; upper bits are carried unmodified.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active‑low
- a_wait  in  1  downstream stall; freezes every pipeline register
- flush  in  1  clears info bit 0 in all stages
- busy  out  1  equals a_wait
- info_in  in  info_width  sideband; bit 0 is valid
- operand  in  64  packed value; single uses [31:0] and ignores [63:32]
- is_double  in  1  1 selects double, 0 selects single
- fs  in  1  FCSR.FS; when 1, denormal inputs are flushed to zero
- info_out  out  info_width  sideband delayed 2 cycles
- sign  out  1  operand sign
- exp  out  13  two's‑complement exponent, bias 1023; may be negative
- frac  out  108  significand [107:105].[104:0]; bits [107:105] are always 0
- is_zero, is_inf, is_nan, is_snan, is_denorm  out  1 each  class flags

## Operation
- Field extraction:
  - Double: e = operand[62:52], f = operand[51:0], aligned at frac[103:52].
  - Single: e = operand[30:23], f = operand[22:0], aligned at frac[103:81].
  - All lower frac bits are 0.
- Normal input (e ≠ 0, e ≠ all‑ones):
  - frac[104] = 1.
  - exp = e for double; exp = e + 896 for single.
- Zero input (e = 0, f = 0): is_zero = 1, exp = 0, frac = 0, sign preserved.
- Denormal input (e = 0, f ≠ 0): is_denorm = 1.
  - lz = count of leading zeros of f (52 bits for double, 23 bits for single).
  - Shift f left by lz + 1, so its leading 1 lands on bit 104.
  - exp = −lz for double; exp = 896 − lz for single.
  - If fs = 1: frac = 0, exp = 0, is_zero = 1. is_denorm stays 1 and sign is preserved.
- Inf/NaN input (e all‑ones): exp = 2047 for both formats, frac[104] = 1, raw f aligned as for a normal input.
  - f = 0: is_inf = 1.
  - f ≠ 0: is_nan = 1.
  - is_snan = is_nan & f MSB. This is the MIPS legacy encoding; 7fbfffff and 7ff7ffffffffffff are the quiet NaNs.
- Class flags are mutually exclusive, except is_denorm with is_zero under fs = 1, and is_snan with is_nan.
- Exponent arithmetic uses 13‑bit two's complement; no saturation is needed. The range is −51 to 2047.

## Timing
- Latency is exactly 2 cycles from input to output when a_wait = 0. Throughput is 1 per cycle.
- Stage 0 registers: class flags, sign, lz (from the leading‑zero counter), raw f, pre‑biased exponent, info.
- Stage 1 registers: shifted frac, final exp, all outputs.
- a_wait = 1: every stage holds its contents, including info. busy = a_wait.
- flush = 1: info bit 0 is cleared in both stages and in info_out on that edge. Flush overrides a_wait. Other bits follow the normal a_wait rule.
- Reset: every stage register and every output is 0. A reset mid‑operation discards in‑flight operands.
- is_double and fs are sampled with operand in stage 0 and travel with the data.

## Structure
- Constants go in defs.h:
  - `SINGLE_EXP_OFFSET (896)
  - `DOUBLE_EXP_MAX (2047)
  - `FRAC_HIDDEN_BIT (104)
  - the default quiet‑NaN patterns shared with f_round
- Sub‑module f_lzc53: a combinational 53‑bit leading‑zero counter with a 6‑bit count. The single path feeds f left‑justified with trailing 1s padding. It is instantiated once in stage 0.

## Test plan
- Double 3FF0000000000000 → after 2 cycles: exp 1023, frac = 1<<104, all flags 0.
- Single 3F800000 → exp 1023, frac = 1<<104. Single 7F7FFFFF → exp 1150, frac[104:81] all 1.
- Double 0000000000000001, fs = 0 → is_denorm, exp 13'h1FCD (−51), frac = 1<<104. Single 00000001 → exp 874, frac = 1<<104.
- Single 80000001 with fs = 1 → is_zero = 1, is_denorm = 1, sign = 1, frac = 0, exp = 0.
- Single 7F800000 → is_inf, exp 2047. Single 7FC00000 → is_nan and is_snan. Double 7FF7FFFFFFFFFFFF → is_nan only.
- Back‑to‑back stream with a_wait pulsed for 3 cycles and flush on cycle 5 → outputs are held during the stall, the flushed entries emerge with info_out[0] = 0, and no other reordering or loss occurs.
